dac_sample_pacer: RTL and testbench



---
 rtl/dac_pacer_pkg.sv | 20 ++
 rtl/dac_sample_fifo.sv | 78 +++++++
 rtl/dac_sample_pacer.sv | 205 ++++++++++++++++++++
 tb/tb_dac_sample_pacer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pacer_pkg.sv
// ----------------------------------------------------------------------------
// dac_pacer_pkg
// Shared types and constants for the DAC sample pacer.
//   pacer_state_e   : pacing state machine encoding (IDLE, RUN)
//   DAC_W           : DAC code width (16-bit straight binary)
//   DEF_MIN_GAP     : default minimum clk cycles between dv strobes
//   DEF_LDAC_DELAY  : default clk cycles from dv to ldac_n falling
// ----------------------------------------------------------------------------
package dac_pacer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pacer_state_e;

    localparam int DAC_W          = 16;
    localparam int DEF_MIN_GAP    = 320;
    localparam int DEF_LDAC_DELAY = 304;

endpackage

// File: rtl/dac_sample_fifo.sv
// ----------------------------------------------------------------------------
// dac_sample_fifo
// Synchronous FIFO holding DAC codes between the producer and the pacer.
// Read data is the current head word; the consumer registers it on pop.
// Pushes when full and pops when empty are ignored.
// Ports:
//   clk    in           : clock
//   reset  in           : asynchronous active-high reset (empties the FIFO)
//   push   in           : write wdata
//   pop    in           : discard head word
//   wdata  in  [WIDTH]  : write data
//   rdata  out [WIDTH]  : head word
//   full   out          : level == DEPTH
//   empty  out          : level == 0
//   level  out [AW+1]   : current occupancy
// ----------------------------------------------------------------------------
module dac_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/dac_sample_pacer.sv
// ----------------------------------------------------------------------------
// dac_sample_pacer
// Buffers 16-bit DAC codes and releases them as one-cycle dv strobes on a
// programmable sample grid for the ad5541_spi driver, then issues a 2-cycle
// active-low ldac_n pulse LDAC_DELAY cycles after each dv.
// Interval = max(period, MIN_GAP), latched at every tick.
//
// Optional build macro: DAC_PACER_RAMP_EN
//   Adds ramp_mode / ramp_step. With ramp_mode=1 ticks emit an internal
//   wrapping accumulator instead of FIFO data and never flag underrun.
//
// Ports:
//   clk          in           : system clock
//   reset        in           : asynchronous active-high reset
//   enable       in           : run/stop pacing
//   period       in [PERIOD_W]: requested sample interval (clk cycles)
//   s_valid      in           : producer sample valid
//   s_ready      out          : FIFO can accept (not full)
//   s_data       in [16]      : producer DAC code
//   dv           out          : one-cycle strobe to the driver
//   tx_data      out [16]     : code to the driver, held between strobes
//   ldac_n       out          : DAC load pulse, active low
//   fifo_level   out          : FIFO occupancy
//   underrun     out          : sticky, set when a tick finds the FIFO empty
//   underrun_clr in           : synchronous clear of underrun
//   ramp_mode    in           : (ramp build only) select ramp source
//   ramp_step    in [16]      : (ramp build only) ramp increment per tick
// ----------------------------------------------------------------------------
module dac_sample_pacer
    import dac_pacer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD_W   = 16,
    parameter int MIN_GAP    = DEF_MIN_GAP,
    parameter int LDAC_DELAY = DEF_LDAC_DELAY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           period,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DAC_W-1:0]              s_data,
    output logic                          dv,
    output logic [DAC_W-1:0]              tx_data,
    output logic                          ldac_n,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr
`ifdef DAC_PACER_RAMP_EN
    ,
    input  logic                          ramp_mode,
    input  logic [DAC_W-1:0]              ramp_step
`endif
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int CNT_W = (PERIOD_W > GAP_W) ? PERIOD_W : GAP_W;
    localparam int DLY_W = $clog2(LDAC_DELAY + 1);

    pacer_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dv_q;
    logic [DAC_W-1:0] tx_data_q;
    logic             ldac_n_q;
    logic             ldac_hold_q;
    logic [DLY_W-1:0] dly_q;
    logic             underrun_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DAC_W-1:0] fifo_rdata;
    logic             push;
    logic             pop;
    logic             tick;
    logic             emit;
    logic             use_ramp;
    logic             ldac_busy;
    logic [CNT_W-1:0] period_ext;
    logic [CNT_W-1:0] interval;

    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;

    dac_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DAC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef DAC_PACER_RAMP_EN
    logic [DAC_W-1:0] ramp_acc_q;

    assign use_ramp = ramp_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_acc_q <= '0;
        end else if (emit && use_ramp) begin
            ramp_acc_q <= ramp_acc_q + ramp_step;
        end
    end
`else
    assign use_ramp = 1'b0;
`endif

    // period = 0 and anything below MIN_GAP both clamp to MIN_GAP.
    assign period_ext = CNT_W'(period);
    assign interval   = (period_ext < CNT_W'(MIN_GAP)) ? CNT_W'(MIN_GAP) : period_ext;

    // A tick fires when the countdown reaches zero; the grid keeps running
    // through empty ticks so later samples stay phase-aligned.
    assign tick      = (state_q == RUN) && enable && (cnt_q == '0);
    assign emit      = tick && (use_ramp || !fifo_empty);
    assign pop       = tick && !use_ramp && !fifo_empty;
    assign ldac_busy = (dly_q != '0) || !ldac_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dv_q        <= 1'b0;
            tx_data_q   <= '0;
            ldac_n_q    <= 1'b1;
            ldac_hold_q <= 1'b0;
            dly_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            dv_q <= emit;
`ifdef DAC_PACER_RAMP_EN
            if (emit) begin
                tx_data_q <= use_ramp ? ramp_acc_q : fifo_rdata;
            end
`else
            if (emit) begin
                tx_data_q <= fifo_rdata;
            end
`endif

            // Set has priority over a coincident clear.
            if (tick && !use_ramp && fifo_empty) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // Counter at zero makes the very next RUN cycle a tick.
                    if (enable && (use_ramp || !fifo_empty)) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (cnt_q == '0) begin
                            cnt_q <= interval - CNT_W'(1);
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end else if (!ldac_busy) begin
                        // Stop only after the outstanding load pulse is done.
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // LDAC delay: falls when the countdown leaves 1, stays low two
            // cycles. LDAC_DELAY < MIN_GAP - 2 keeps pulses from overlapping.
            if (emit) begin
                dly_q <= DLY_W'(LDAC_DELAY);
            end else if (dly_q != '0) begin
                dly_q <= dly_q - DLY_W'(1);
            end

            if (dly_q == DLY_W'(1)) begin
                ldac_n_q    <= 1'b0;
                ldac_hold_q <= 1'b1;
            end else if (!ldac_n_q) begin
                if (ldac_hold_q) begin
                    ldac_hold_q <= 1'b0;
                end else begin
                    ldac_n_q <= 1'b1;
                end
            end
        end
    end

    assign dv       = dv_q;
    assign tx_data  = tx_data_q;
    assign ldac_n   = ldac_n_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
module tb_dac_sample_pacer;

    localparam int DEPTH      = 8;
    localparam int MIN_GAP    = 320;
    localparam int LDAC_DELAY = 304;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] period;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        dv;
    logic [15:0] tx_data;
    logic        ldac_n;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic        underrun_clr;
`ifdef DAC_PACER_RAMP_EN
    logic        ramp_mode;
    logic [15:0] ramp_step;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [15:0] model_q[$];

    dac_sample_pacer #(
        .FIFO_DEPTH (DEPTH),
        .PERIOD_W   (16),
        .MIN_GAP    (MIN_GAP),
        .LDAC_DELAY (LDAC_DELAY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .dv           (dv),
        .tx_data      (tx_data),
        .ldac_n       (ldac_n),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
`ifdef DAC_PACER_RAMP_EN
        ,
        .ramp_mode    (ramp_mode),
        .ramp_step    (ramp_step)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_interval(input int p);
        return (p < MIN_GAP) ? MIN_GAP : p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bit acc;
        s_valid = 1'b1;
        s_data  = d;
        acc     = s_ready;
        step();
        s_valid = 1'b0;
        if (acc) model_q.push_back(d);
    endtask

    // Steps until dv is seen or max_cyc expires; records the ldac_n low
    // window relative to 'start'. Returns observations only.
    task automatic watch(input int max_cyc, input int start, output bit got,
                         output int dv_at, output int fall_off, output int low_w);
        got = 1'b0; dv_at = -1; fall_off = -1; low_w = 0;
        for (int k = 0; k < max_cyc; k++) begin
            step();
            if (ldac_n === 1'b0) begin
                if (fall_off < 0) fall_off = cyc - start;
                low_w++;
            end
            if (dv === 1'b1) begin
                got = 1'b1;
                dv_at = cyc;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1; enable = 1'b0; period = 16'd0; s_valid = 1'b0;
        s_data = 16'd0; underrun_clr = 1'b0;
`ifdef DAC_PACER_RAMP_EN
        ramp_mode = 1'b0; ramp_step = 16'd0;
`endif
        step(); step();
        reset = 1'b0;
        step();
        model_q.delete();
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (dv !== 1'b0 || tx_data !== 16'h0 || ldac_n !== 1'b1 || underrun !== 1'b0 ||
            s_ready !== 1'b1 || fifo_level !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values: dv=%b tx=%h ldac_n=%b ur=%b rdy=%b lvl=%0d required 0 0000 1 0 1 0",
                     dv, tx_data, ldac_n, underrun, s_ready, fifo_level);
        end
        $display("test_reset: reset values checked");
    endtask

    task automatic test_basic();
        bit got; int c0, t0, t1, t2, fo, lw; logic [15:0] e;
        reset_dut();
        push(16'h1234);
        push(16'hABCD);
        n_checks++;
        if (fifo_level !== 4'd2) begin
            n_fail++; $display("FAIL basic_level: got %0d required 2", fifo_level);
        end
        period = 16'd400; enable = 1'b1; c0 = cyc;
        watch(20, cyc, got, t0, fo, lw);
        e = model_q.pop_front();
        n_checks++;
        if (!got || t0 - c0 != 2 || tx_data !== e) begin
            n_fail++; $display("FAIL basic_first_dv: got=%0d latency=%0d tx=%h required 1 2 %h", got, t0 - c0, tx_data, e);
        end
        watch(500, t0, got, t1, fo, lw);
        e = model_q.pop_front();
        n_checks++;
        if (t1 - t0 != 400 || tx_data !== e) begin
            n_fail++; $display("FAIL basic_second_dv: spacing=%0d tx=%h required 400 %h", t1 - t0, tx_data, e);
        end
        n_checks++;
        if (fo != LDAC_DELAY || lw != 2) begin
            n_fail++; $display("FAIL basic_ldac1: offset=%0d width=%0d required %0d 2", fo, lw, LDAC_DELAY);
        end
        watch(350, t1, got, t2, fo, lw);
        n_checks++;
        if (got || fo != LDAC_DELAY || lw != 2) begin
            n_fail++; $display("FAIL basic_ldac2: dv=%0d offset=%0d width=%0d required 0 %0d 2", got, fo, lw, LDAC_DELAY);
        end
        $display("test_basic: dv at %0d and %0d", t0, t1);
    endtask

    task automatic test_period_clamp();
        bit got; int p, iv, t0, t1, t2, fo, lw; logic [15:0] e;
        for (int i = 0; i < 3; i++) begin
            reset_dut();
            p = (i == 0) ? 100 : (i == 1) ? 0 : int'($urandom_range(321, 700));
            iv = exp_interval(p);
            for (int j = 0; j < 3; j++) push(16'($urandom));
            period = 16'(p); enable = 1'b1;
            watch(30, cyc, got, t0, fo, lw);
            e = model_q.pop_front();
            n_checks++;
            if (!got || tx_data !== e) begin
                n_fail++; $display("FAIL clamp_first p=%0d: got=%0d tx=%h required 1 %h", p, got, tx_data, e);
            end
            watch(800, t0, got, t1, fo, lw);
            e = model_q.pop_front();
            n_checks++;
            if (t1 - t0 != iv || tx_data !== e) begin
                n_fail++; $display("FAIL clamp_second p=%0d: spacing=%0d tx=%h required %0d %h", p, t1 - t0, tx_data, iv, e);
            end
            watch(800, t1, got, t2, fo, lw);
            e = model_q.pop_front();
            n_checks++;
            if (t2 - t1 != iv || tx_data !== e) begin
                n_fail++; $display("FAIL clamp_third p=%0d: spacing=%0d tx=%h required %0d %h", p, t2 - t1, tx_data, iv, e);
            end
            $display("test_period_clamp: period=%0d spacing %0d / %0d", p, t1 - t0, t2 - t1);
        end
    endtask

    task automatic test_full();
        bit got; int t0, t1, fo, lw; logic [15:0] e;
        reset_dut();
        for (int j = 0; j < DEPTH; j++) push(16'($urandom));
        n_checks++;
        if (s_ready !== 1'b0 || fifo_level !== 4'd8) begin
            n_fail++; $display("FAIL full_state: rdy=%b lvl=%0d required 0 8", s_ready, fifo_level);
        end
        push(16'hDEAD);   // refused: model only records accepted words
        n_checks++;
        if (fifo_level !== 4'd8 || model_q.size() != DEPTH) begin
            n_fail++; $display("FAIL full_ninth: lvl=%0d required 8", fifo_level);
        end
        period = 16'd0; enable = 1'b1;
        step();
        n_checks++;
        if (s_ready !== 1'b0 || dv !== 1'b0) begin
            n_fail++; $display("FAIL full_pre_tick: rdy=%b dv=%b required 0 0", s_ready, dv);
        end
        step();
        e = model_q.pop_front();
        n_checks++;
        if (dv !== 1'b1 || s_ready !== 1'b1 || fifo_level !== 4'd7 || tx_data !== e) begin
            n_fail++; $display("FAIL full_after_tick: dv=%b rdy=%b lvl=%0d tx=%h required 1 1 7 %h", dv, s_ready, fifo_level, tx_data, e);
        end
        t0 = cyc;
        for (int j = 1; j < DEPTH; j++) begin
            watch(400, t0, got, t1, fo, lw);
            e = model_q.pop_front();
            n_checks++;
            if (t1 - t0 != MIN_GAP || tx_data !== e) begin
                n_fail++; $display("FAIL full_drain%0d: spacing=%0d tx=%h required %0d %h", j, t1 - t0, tx_data, MIN_GAP, e);
            end
            t0 = t1;
        end
        watch(MIN_GAP + 5, t0, got, t1, fo, lw);
        n_checks++;
        if (got || underrun !== 1'b1) begin
            n_fail++; $display("FAIL full_no_ninth: dv=%0d ur=%b required 0 1", got, underrun);
        end
        $display("test_full: drained %0d words", DEPTH);
    endtask

    task automatic test_underrun();
        bit got; int t0, t1, fo, lw; logic [15:0] e, held;
        reset_dut();
        push(16'h5A5A);
        period = 16'd400; enable = 1'b1;
        watch(20, cyc, got, t0, fo, lw);
        e = model_q.pop_front(); held = e;
        n_checks++;
        if (!got || tx_data !== e) begin
            n_fail++; $display("FAIL underrun_dv: got=%0d tx=%h required 1 %h", got, tx_data, e);
        end
        watch(399 - 1, t0, got, t1, fo, lw);   // now at t0+398
        step();                                // t0+399
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL underrun_early: got %b required 0", underrun);
        end
        step();                                // t0+400: empty tick
        n_checks++;
        if (underrun !== 1'b1 || dv !== 1'b0 || tx_data !== held) begin
            n_fail++; $display("FAIL underrun_set: ur=%b dv=%b tx=%h required 1 0 %h", underrun, dv, tx_data, held);
        end
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL underrun_clr: got %b required 0", underrun);
        end
        // Hold clear across the next empty tick at t0+800: set must win.
        repeat (397) step();                   // t0+798
        underrun_clr = 1'b1;
        step();                                // t0+799
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL underrun_pre_collide: got %b required 0", underrun);
        end
        step();                                // t0+800
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++; $display("FAIL underrun_set_wins: got %b required 1", underrun);
        end
        underrun_clr = 1'b0;
        $display("test_underrun: empty ticks flagged at t0+400 and t0+800");
    endtask

    task automatic test_disable();
        bit got; int c0, t0, t1, fo, lw; logic [15:0] e;
        reset_dut();
        for (int j = 0; j < 3; j++) push(16'($urandom));
        period = 16'd0; enable = 1'b1;
        watch(20, cyc, got, t0, fo, lw);
        void'(model_q.pop_front());
        enable = 1'b0;
        watch(1000, t0, got, t1, fo, lw);
        n_checks++;
        if (got || fo != LDAC_DELAY || lw != 2 || fifo_level !== 4'd2) begin
            n_fail++; $display("FAIL disable_hold: dv=%0d offset=%0d width=%0d lvl=%0d required 0 %0d 2 2",
                               got, fo, lw, fifo_level, LDAC_DELAY);
        end
        c0 = cyc; enable = 1'b1;
        watch(20, cyc, got, t1, fo, lw);
        e = model_q.pop_front();
        n_checks++;
        if (!got || t1 - c0 != 2 || tx_data !== e) begin
            n_fail++; $display("FAIL disable_resume: got=%0d latency=%0d tx=%h required 1 2 %h", got, t1 - c0, tx_data, e);
        end
        $display("test_disable: resumed at %0d", t1);
    endtask

    task automatic test_reset_midframe();
        bit got; int t0, t1, fo, lw;
        reset_dut();
        push(16'hCAFE); push(16'hBEEF);
        period = 16'd0; enable = 1'b1;
        watch(20, cyc, got, t0, fo, lw);
        repeat (10) step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx_data !== 16'h0 || fifo_level !== 4'd0 || ldac_n !== 1'b1 || dv !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid: tx=%h lvl=%0d ldac_n=%b dv=%b rdy=%b required 0000 0 1 0 1",
                               tx_data, fifo_level, ldac_n, dv, s_ready);
        end
        step();
        reset = 1'b0;
        model_q.delete();
        watch(400, t0, got, t1, fo, lw);
        n_checks++;
        if (got || fo != -1) begin
            n_fail++; $display("FAIL reset_mid_quiet: dv=%0d ldac_low_offset=%0d required 0 -1", got, fo);
        end
        $display("test_reset_midframe: no ldac pulse after reset");
    endtask

    task automatic test_random();
        int p, iv, rate, next_tick, last_dv, dv_err, ldac_err, lvl_err, ndv;
        bit do_push, acc; logic [15:0] d, e; logic exp_ldac;
        for (int run = 0; run < 3; run++) begin
            reset_dut();
            p = int'($urandom_range(0, 700));
            iv = exp_interval(p);
            rate = (run == 0) ? 40 : (run == 1) ? 500 : 150;
            period = 16'(p); enable = 1'b1;
            next_tick = -1; last_dv = -100000;
            dv_err = 0; ldac_err = 0; lvl_err = 0; ndv = 0;
            for (int k = 0; k < 3000; k++) begin
                do_push = ($urandom_range(0, rate - 1) == 0);
                d = 16'($urandom);
                s_valid = do_push; s_data = d;
                acc = do_push && (s_ready === 1'b1);
                step();
                s_valid = 1'b0;
                if (next_tick >= 0 && cyc == next_tick) begin
                    next_tick += iv;
                    n_checks++;
                    if (model_q.size() != 0) begin
                        e = model_q.pop_front();
                        last_dv = cyc; ndv++;
                        if (dv !== 1'b1 || tx_data !== e) begin
                            n_fail++; $display("FAIL rand_tick run%0d cyc%0d: dv=%b tx=%h required 1 %h", run, cyc, dv, tx_data, e);
                        end
                    end else if (dv !== 1'b0 || underrun !== 1'b1) begin
                        n_fail++; $display("FAIL rand_empty_tick run%0d cyc%0d: dv=%b ur=%b required 0 1", run, cyc, dv, underrun);
                    end
                end else if (dv !== 1'b0) begin
                    dv_err++;
                end
                if (acc) begin
                    model_q.push_back(d);
                    if (next_tick < 0) next_tick = cyc + 2;
                end
                exp_ldac = !((cyc - last_dv == LDAC_DELAY) || (cyc - last_dv == LDAC_DELAY + 1));
                if (ldac_n !== exp_ldac) ldac_err++;
                if (int'(fifo_level) != model_q.size() || s_ready !== (model_q.size() < DEPTH)) lvl_err++;
            end
            n_checks++;
            if (dv_err != 0 || ldac_err != 0 || lvl_err != 0) begin
                n_fail++; $display("FAIL rand_run%0d: stray_dv=%0d ldac_err=%0d level_err=%0d required 0 0 0", run, dv_err, ldac_err, lvl_err);
            end
            $display("test_random: run %0d period=%0d interval=%0d dv_count=%0d", run, p, iv, ndv);
        end
    endtask

`ifdef DAC_PACER_RAMP_EN
    task automatic test_ramp();
        bit got; int t0, t1, fo, lw; logic [15:0] e;
        reset_dut();
        ramp_mode = 1'b1; ramp_step = 16'h4000; period = 16'd0; enable = 1'b1;
        e = 16'h0000; t0 = cyc;
        for (int j = 0; j < 5; j++) begin
            watch(400, t0, got, t1, fo, lw);
            n_checks++;
            if (!got || tx_data !== e) begin
                n_fail++; $display("FAIL ramp_%0d: got=%0d tx=%h required 1 %h", j, got, tx_data, e);
            end
            e = e + 16'h4000; t0 = t1;
        end
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL ramp_underrun: got %b required 0", underrun);
        end
        ramp_mode = 1'b0;
        $display("test_ramp: five ramp codes emitted");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_period_clamp();
        test_full();
        test_underrun();
        test_disable();
        test_reset_midframe();
        test_random();
`ifdef DAC_PACER_RAMP_EN
        test_ramp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
